// File: rtl/pe_sequencer_pkg.sv
// Shared types and defaults for the PE job sequencer and its credit counter.
package pe_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEFAULT_WEIGHT_DEPTH = 4;
    localparam int DEFAULT_MAX_OUT      = 8;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_bits(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pe_credit_counter.sv
// Up/down count of results issued to the PE but not yet returned; saturates at
// both ends and grants credit while below MAX_OUT.
module pe_credit_counter
    import pe_sequencer_pkg::*;
#(
    parameter int MAX_OUT = DEFAULT_MAX_OUT,
    parameter int CW      = cnt_bits(DEFAULT_MAX_OUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic credit,
    output logic empty_next
);

    localparam logic [CW-1:0] MAX_VAL = CW'(MAX_OUT);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          inc_eff;
    logic          dec_eff;

    // A return with nothing outstanding is a stray pulse and must not wrap.
    assign inc_eff = inc && (count != MAX_VAL);
    assign dec_eff = dec && (count != '0);

    always_comb begin
        // NOTE: assign a default first so every path drives count_next and no latch is inferred.
        count_next = count;
        if (inc_eff && !dec_eff) begin
            count_next = count + 1'b1;
        end else if (dec_eff && !inc_eff) begin
            count_next = count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign credit     = (count < MAX_VAL);
    assign empty_next = (count_next == '0);

endmodule

// File: rtl/pe_sequencer.sv
// Job sequencer for one processing element: streams a weight burst into the PE,
// then issues cfg_len data beats under a credit limit and waits for all results.
module pe_sequencer
    import pe_sequencer_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 16,
    parameter int WEIGHT_DEPTH = DEFAULT_WEIGHT_DEPTH,
    parameter int CNT_WIDTH    = 16,
    parameter int MAX_OUT      = DEFAULT_MAX_OUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    cfg_len,
    input  logic                    cfg_mode,
    input  logic                    cfg_add_sub_enable,
    output logic                    busy,
    output logic                    done,
    input  logic                    w_tvalid,
    output logic                    w_tready,
    input  logic [WEIGHT_WIDTH-1:0] w_tdata,
    output logic [WEIGHT_WIDTH-1:0] pe_weight_in,
    output logic                    pe_weight_in_tvalid,
    input  logic                    pe_weight_in_tready,
    output logic                    pe_weight_load_enable,
    output logic                    pe_mode,
    output logic                    pe_add_sub_enable,
    input  logic                    src_tvalid,
    output logic                    src_tready,
    output logic                    pe_in_tvalid,
    input  logic                    pe_in_tready,
    input  logic                    res_tvalid,
    input  logic                    res_tready
);

    localparam int WCW = cnt_bits(WEIGHT_DEPTH);
    localparam int OCW = cnt_bits(MAX_OUT);

    localparam logic [WCW-1:0]       W_LAST   = WCW'(WEIGHT_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] LEN_LAST = CNT_WIDTH'(1);

    state_t               state;
    logic [WCW-1:0]       w_cnt;
    logic [CNT_WIDTH-1:0] remaining;

    logic in_load;
    logic in_run;
    logic credit;
    logic empty_next;
    logic w_hs;
    logic issue;
    logic ret;

    assign in_load = (state == LOAD);
    assign in_run  = (state == RUN);

    assign w_hs  = in_load && w_tvalid && pe_weight_in_tready;
    assign issue = in_run && src_tvalid && pe_in_tready && credit;
    assign ret   = res_tvalid && res_tready;

    // Weight path is a straight pass-through, gated off outside LOAD.
    assign w_tready              = in_load && pe_weight_in_tready;
    assign pe_weight_in_tvalid   = in_load && w_tvalid;
    assign pe_weight_in          = in_load ? w_tdata : '0;
    assign pe_weight_load_enable = in_load;

    // Data and vertical input move as one beat; both sides see the credit gate.
    assign pe_in_tvalid = in_run && src_tvalid && credit;
    assign src_tready   = in_run && pe_in_tready && credit;

    pe_credit_counter #(
        .MAX_OUT (MAX_OUT),
        .CW      (OCW)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .inc        (issue),
        .dec        (ret),
        .credit     (credit),
        .empty_next (empty_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            w_cnt             <= '0;
            remaining         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            pe_mode           <= 1'b0;
            pe_add_sub_enable <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state             <= LOAD;
                        busy              <= 1'b1;
                        w_cnt             <= '0;
                        remaining         <= cfg_len;
                        pe_mode           <= cfg_mode;
                        pe_add_sub_enable <= cfg_add_sub_enable;
                    end
                end
                LOAD: begin
                    if (w_hs) begin
                        if (w_cnt == W_LAST) begin
                            w_cnt <= '0;
                            // A zero-length job only refreshes the weights.
                            if (remaining == '0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Looking at the next count lets done follow the last return by one cycle.
                    if (empty_next) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: stimulus queues expected weights and job
// outcomes, a negedge monitor pops and compares them as the DUT responds.
module tb_pe_sequencer;

    localparam int WW      = 16;
    localparam int WDEPTH  = 4;
    localparam int CW      = 16;
    localparam int MAX_OUT = 8;

    typedef struct {
        int   n_wt;
        int   n_iss;
        logic mode;
        logic en;
    } job_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_len = '0;
    logic          cfg_mode = 1'b0;
    logic          cfg_add_sub_enable = 1'b0;
    logic          busy;
    logic          done;
    logic          w_tvalid;
    logic          w_tready;
    logic [WW-1:0] w_tdata;
    logic [WW-1:0] pe_weight_in;
    logic          pe_weight_in_tvalid;
    logic          pe_weight_in_tready = 1'b1;
    logic          pe_weight_load_enable;
    logic          pe_mode;
    logic          pe_add_sub_enable;
    logic          src_tvalid;
    logic          src_tready;
    logic          pe_in_tvalid;
    logic          pe_in_tready = 1'b1;
    logic          res_tvalid;
    logic          res_tready = 1'b1;

    // Source / PE models
    logic [WW-1:0] w_mem [64];
    int  w_num = 0;
    int  w_idx = 0;
    bit  w_en = 1'b1;
    int  src_limit = 0;
    bit  src_en = 1'b1;
    int  issued_total = 0;
    int  pending = 0;
    bit  res_allow = 1'b1;
    bit  res_force = 1'b0;
    bit  r_eff;

    // Monitor state
    int  cyc = 0;
    bit  rst_s = 1'b1;
    bit  f_wt, f_iss, f_ret;
    int  job_wt = 0, job_iss = 0, early = 0, over = 0, last_evt = 0, n_done = 0;

    int  n_vec = 0;
    int  n_err = 0;

    logic [WW-1:0] exp_wt[$];
    job_t          exp_job[$];

    assign w_tvalid   = w_en && (w_idx < w_num);
    assign w_tdata    = w_mem[w_idx[5:0]];
    assign src_tvalid = src_en && (issued_total < src_limit);
    assign res_tvalid = ((pending > 0) && res_allow) || res_force;

    pe_sequencer #(
        .WEIGHT_WIDTH (WW),
        .WEIGHT_DEPTH (WDEPTH),
        .CNT_WIDTH    (CW),
        .MAX_OUT      (MAX_OUT)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .cfg_len               (cfg_len),
        .cfg_mode              (cfg_mode),
        .cfg_add_sub_enable    (cfg_add_sub_enable),
        .busy                  (busy),
        .done                  (done),
        .w_tvalid              (w_tvalid),
        .w_tready              (w_tready),
        .w_tdata               (w_tdata),
        .pe_weight_in          (pe_weight_in),
        .pe_weight_in_tvalid   (pe_weight_in_tvalid),
        .pe_weight_in_tready   (pe_weight_in_tready),
        .pe_weight_load_enable (pe_weight_load_enable),
        .pe_mode               (pe_mode),
        .pe_add_sub_enable     (pe_add_sub_enable),
        .src_tvalid            (src_tvalid),
        .src_tready            (src_tready),
        .pe_in_tvalid          (pe_in_tvalid),
        .pe_in_tready          (pe_in_tready),
        .res_tvalid            (res_tvalid),
        .res_tready            (res_tready)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: handshakes are evaluated half a cycle before the edge that takes them.
    always @(negedge clk) begin
        cyc++;
        rst_s = rst;
        f_wt  = !rst && pe_weight_in_tvalid && pe_weight_in_tready;
        f_iss = !rst && pe_in_tvalid && pe_in_tready;
        f_ret = !rst && res_tvalid && res_tready;
        if (rst) begin
            job_wt = 0; job_iss = 0; early = 0; over = 0;
        end else begin
            if (f_wt) begin
                if (exp_wt.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL extra_weight_hs: got data %0h, expected no handshake", pe_weight_in);
                end else begin
                    check("weight_data", pe_weight_in, exp_wt.pop_front());
                    check("weight_load_en", pe_weight_load_enable, 1);
                end
                job_wt++;
                last_evt = cyc;
            end
            if ((pe_in_tvalid || src_tready) && job_wt < WDEPTH) early++;
            if (f_iss) begin
                if (pending >= MAX_OUT) over++;
                job_iss++;
            end
            if (f_ret) last_evt = cyc;
            if (done) begin
                n_done++;
                if (exp_job.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done: got done=1, expected none (t=%0t)", $time);
                end else begin
                    job_t j;
                    j = exp_job.pop_front();
                    check("done_weight_hs", job_wt, j.n_wt);
                    check("done_issues", job_iss, j.n_iss);
                    check("done_latency", cyc - last_evt, 1);
                    check("busy_at_done", busy, 0);
                    check("mode_held", pe_mode, j.mode);
                    check("addsub_held", pe_add_sub_enable, j.en);
                    check("run_before_load_end", early, 0);
                    check("over_issue", over, 0);
                end
                job_wt = 0; job_iss = 0; early = 0; over = 0;
            end
        end
    end

    // Source/PE bookkeeping, applied just after the edge that took the handshakes.
    always begin
        @(posedge clk);
        #1;
        if (rst_s) begin
            pending = 0;
        end else begin
            r_eff = f_ret && (pending > 0);
            if (f_wt) w_idx++;
            if (f_iss) issued_total++;
            pending = pending + (f_iss ? 1 : 0) - (r_eff ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_weights(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                input logic [WW-1:0] c, input logic [WW-1:0] d);
        w_mem[w_num]     = a; exp_wt.push_back(a);
        w_mem[w_num + 1] = b; exp_wt.push_back(b);
        w_mem[w_num + 2] = c; exp_wt.push_back(c);
        w_mem[w_num + 3] = d; exp_wt.push_back(d);
        w_num += 4;
    endtask

    task automatic start_job(input int len, input logic mode, input logic en, input bit expect_job);
        job_t j;
        cfg_len            = CW'(len);
        cfg_mode           = mode;
        cfg_add_sub_enable = en;
        start              = 1'b1;
        if (expect_job) begin
            j.n_wt = WDEPTH; j.n_iss = len; j.mode = mode; j.en = en;
            exp_job.push_back(j);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (exp_job.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("job_done_timeout", exp_job.size(), 0);
        exp_job.delete();
    endtask

    task automatic wait_issued(input int target, input int budget);
        int k = 0;
        while (issued_total < target && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pe_mode"}, pe_mode, 0);
        check({tag, "_pe_addsub"}, pe_add_sub_enable, 0);
        check({tag, "_pe_weight_in"}, pe_weight_in, 0);
        check({tag, "_w_tready"}, w_tready, 0);
        check({tag, "_wt_tvalid"}, pe_weight_in_tvalid, 0);
        check({tag, "_load_en"}, pe_weight_load_enable, 0);
        check({tag, "_src_tready"}, src_tready, 0);
        check({tag, "_pe_in_tvalid"}, pe_in_tvalid, 0);
    endtask

    initial begin
        int base;
        int done_before;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic job: 4 weights, 8 beats, PE always ready
        base = issued_total;
        src_limit = base + 8;
        push_weights(16'h4000, 16'hC000, 16'h3800, 16'h4200);
        start_job(8, 1'b1, 1'b1, 1'b1);
        check("busy_after_start", busy, 1);
        wait_done(200);
        check("basic_issues", issued_total - base, 8);
        check("basic_busy_idle", busy, 0);

        // Weight stalls from both sides
        base = issued_total;
        src_limit = base + 3;
        w_en = 1'b0;
        push_weights(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        start_job(3, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 24; i++) begin
            w_en                = (i % 3) != 1;
            pe_weight_in_tready = (i % 4) < 2;
            tick();
        end
        w_en = 1'b1;
        pe_weight_in_tready = 1'b1;
        wait_done(200);
        check("stall_issues", issued_total - base, 3);

        // Credit limit with results held, plus a simultaneous issue/return at MAX_OUT-1
        base = issued_total;
        src_limit = base + 7;
        res_allow = 1'b0;
        push_weights(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        start_job(20, 1'b0, 1'b0, 1'b1);
        wait_issued(base + 7, 100);
        repeat (3) tick();
        check("credit_pre_issues", issued_total - base, 7);
        src_limit = base + 8;
        res_allow = 1'b1;
        tick();
        res_allow = 1'b0;
        src_limit = base + 20;
        repeat (10) tick();
        check("stall_at_max_out", issued_total - base, 9);
        check("credit_src_tready", src_tready, 0);
        check("credit_pe_in_tvalid", pe_in_tvalid, 0);
        res_allow = 1'b1;
        wait_done(400);
        check("credit_total_issues", issued_total - base, 20);

        // start during RUN is ignored
        base = issued_total;
        src_limit = base + 6;
        push_weights(16'h5555, 16'h6666, 16'h7777, 16'h8888);
        start_job(6, 1'b1, 1'b0, 1'b1);
        wait_issued(base + 2, 100);
        start_job(5, 1'b0, 1'b1, 1'b0);
        wait_done(200);
        check("ignored_start_issues", issued_total - base, 6);

        // Zero-length job: weights only, single done
        base = issued_total;
        done_before = n_done;
        push_weights(16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        start_job(0, 1'b1, 1'b0, 1'b1);
        wait_done(200);
        repeat (5) tick();
        check("zero_len_issues", issued_total - base, 0);
        check("zero_len_single_done", n_done - done_before, 1);

        // Stray returns with nothing outstanding must not underflow
        res_force = 1'b1;
        repeat (3) tick();
        res_force = 1'b0;
        tick();

        // Reset in RUN after 3 issues aborts without done
        base = issued_total;
        src_limit = base + 3;
        res_allow = 1'b0;
        push_weights(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        start_job(10, 1'b1, 1'b1, 1'b1);
        wait_issued(base + 3, 100);
        tick(); tick();
        check("abort_pre_issues", issued_total - base, 3);
        rst = 1'b1;
        exp_job.delete();
        tick();
        check_reset_outputs("abort");
        rst = 1'b0;
        res_allow = 1'b1;
        done_before = n_done;
        repeat (6) tick();
        check("no_done_after_abort", n_done - done_before, 0);

        // Full job after the abort (also stalls forever if the counter underflowed)
        base = issued_total;
        src_limit = base + 4;
        push_weights(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        start_job(4, 1'b0, 1'b1, 1'b1);
        wait_done(200);
        check("post_abort_issues", issued_total - base, 4);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
